// File: rtl/trigger_debounce.sv
// ---------------------------------------------------------------------------
// trigger_debounce
//
// Purpose:
//   Turns a raw, bouncing push-button input into a clean debounced level and
//   a single-cycle trigger pulse. The trigger pulse drives a downstream 2-bit
//   up-counter stage. The block also keeps a running count of issued
//   triggers.
//
//   The button input is first brought into the clk domain through a 2-flop
//   synchronizer. A 4-state FSM then accepts a level change only after the
//   synchronized input has held the new value for DEBOUNCE_CYCLES
//   consecutive clocks.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable clocks needed to accept a change
//                    (legal range 2..255)
//   PCNT_W           width of the press counter
//
// Ports:
//   clk        in   single clock; all state changes on the rising edge
//   reset      in   asynchronous, active-low reset
//   btn_in     in   raw asynchronous button input
//   t          out  registered one-clock pulse per accepted press
//   btn_level  out  registered debounced level
//   press_cnt  out  registered count of issued t pulses (wraps silently)
// ---------------------------------------------------------------------------
module trigger_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned PCNT_W          = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_in,
  output logic              t,
  output logic              btn_level,
  output logic [PCNT_W-1:0] press_cnt
);

  // FSM encodings. All four codes of the 2-bit register are assigned, so
  // no spare code exists. The default branch still steers to S_LO.
  localparam logic [1:0] S_LO      = 2'b00;
  localparam logic [1:0] S_CONF_HI = 2'b01;
  localparam logic [1:0] S_HI      = 2'b11;
  localparam logic [1:0] S_CONF_LO = 2'b10;

  // Value of the debounce counter on the clock that completes confirmation.
  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  localparam logic [7:0]        CNT_ONE  = 8'd1;
  localparam logic [7:0]        CNT_ZERO = 8'd0;
  localparam logic [PCNT_W-1:0] PCNT_INC = {{(PCNT_W-1){1'b0}}, 1'b1};

  // Returns 1 when a confirmation count has reached its final value. A
  // greater-or-equal test is used so that a corrupted count cannot extend
  // a confirmation indefinitely.
  function automatic logic cnt_done(input logic [7:0] cnt_val);
    cnt_done = (cnt_val >= CNT_LAST) ? 1'b1 : 1'b0;
  endfunction

  // Returns 1 for a state code that belongs to the FSM.
  function automatic logic state_legal(input logic [1:0] st);
    case (st)
      S_LO, S_CONF_HI, S_HI, S_CONF_LO: state_legal = 1'b1;
      default:                          state_legal = 1'b0;
    endcase
  endfunction

  // Registers
  logic              r_s1;
  logic              r_s2;
  logic [1:0]        r_state;
  logic [7:0]        r_cnt;
  logic              r_t;
  logic              r_level;
  logic [PCNT_W-1:0] r_press_cnt;

  // Combinational next-state signals
  logic              w_btn_s;
  logic [1:0]        w_state_nxt;
  logic [7:0]        w_cnt_nxt;
  logic              w_t_nxt;
  logic              w_level_nxt;
  logic [PCNT_W-1:0] w_press_nxt;

  assign w_btn_s = r_s2;

  // Two-flop synchronizer for the asynchronous button input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= btn_in;
      r_s2 <= r_s1;
    end
  end

  // Debounce FSM next-state, counter and output decode.
  always_comb begin
    w_state_nxt = S_LO;
    w_cnt_nxt   = CNT_ZERO;
    w_t_nxt     = 1'b0;
    w_level_nxt = r_level;
    if (!state_legal(r_state)) begin
      // Unknown code: recover to the idle state with no trigger.
      w_state_nxt = S_LO;
      w_cnt_nxt   = CNT_ZERO;
      w_t_nxt     = 1'b0;
      w_level_nxt = r_level;
    end else begin
      case (r_state)
        S_LO: begin
          if (w_btn_s) begin
            w_state_nxt = S_CONF_HI;
            w_cnt_nxt   = CNT_ONE;
          end else begin
            w_state_nxt = S_LO;
            w_cnt_nxt   = CNT_ZERO;
          end
        end
        S_CONF_HI: begin
          if (!w_btn_s) begin
            // The high run was shorter than the debounce window, so drop it.
            w_state_nxt = S_LO;
            w_cnt_nxt   = CNT_ZERO;
          end else if (cnt_done(r_cnt)) begin
            w_state_nxt = S_HI;
            w_cnt_nxt   = CNT_ZERO;
            w_level_nxt = 1'b1;
            w_t_nxt     = 1'b1;
          end else begin
            w_state_nxt = S_CONF_HI;
            w_cnt_nxt   = r_cnt + CNT_ONE;
          end
        end
        S_HI: begin
          if (!w_btn_s) begin
            w_state_nxt = S_CONF_LO;
            w_cnt_nxt   = CNT_ONE;
          end else begin
            w_state_nxt = S_HI;
            w_cnt_nxt   = CNT_ZERO;
          end
        end
        S_CONF_LO: begin
          if (w_btn_s) begin
            // The low gap was too short, so stay pressed without a new trigger.
            w_state_nxt = S_HI;
            w_cnt_nxt   = CNT_ZERO;
          end else if (cnt_done(r_cnt)) begin
            // Accepted release: the level drops and no trigger is issued.
            w_state_nxt = S_LO;
            w_cnt_nxt   = CNT_ZERO;
            w_level_nxt = 1'b0;
          end else begin
            w_state_nxt = S_CONF_LO;
            w_cnt_nxt   = r_cnt + CNT_ONE;
          end
        end
        default: begin
          w_state_nxt = S_LO;
          w_cnt_nxt   = CNT_ZERO;
          w_t_nxt     = 1'b0;
          w_level_nxt = r_level;
        end
      endcase
    end
  end

  // The press counter advances on the same edge that raises t.
  always_comb begin
    if (w_t_nxt) begin
      w_press_nxt = r_press_cnt + PCNT_INC;
    end else begin
      w_press_nxt = r_press_cnt;
    end
  end

  // FSM state and debounce counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_LO;
      r_cnt   <= CNT_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Registered outputs: trigger pulse, debounced level and press count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_t         <= 1'b0;
      r_level     <= 1'b0;
      r_press_cnt <= {PCNT_W{1'b0}};
    end else begin
      r_t         <= w_t_nxt;
      r_level     <= w_level_nxt;
      r_press_cnt <= w_press_nxt;
    end
  end

  assign t         = r_t;
  assign btn_level = r_level;
  assign press_cnt = r_press_cnt;

endmodule

// File: tb/tb_trigger_debounce.sv
module tb_trigger_debounce;

  localparam int D  = 4;
  localparam int PW = 8;

  logic          clk    = 1'b0;
  logic          reset  = 1'b1;
  logic          btn_in = 1'b0;
  logic          t;
  logic          btn_level;
  logic [PW-1:0] press_cnt;

  trigger_debounce #(.DEBOUNCE_CYCLES(D), .PCNT_W(PW)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_in    (btn_in),
    .t         (t),
    .btn_level (btn_level),
    .press_cnt (press_cnt)
  );

  always #20 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard record: the outputs expected after one clock edge
  typedef struct packed {
    logic          e_t;
    logic          e_lvl;
    logic [PW-1:0] e_cnt;
  } sb_rec_t;
  sb_rec_t sb_q[$];

  // Reference model, written as a run-length counter rather than an FSM
  logic          m_s1, m_s2, m_level;
  int            m_run;
  logic [PW-1:0] m_cnt;

  // Stimulus table: one record per segment of constant input
  typedef struct {
    logic btn;
    int   cycles;
    int   exp_pulses;
    int   exp_pulse_at;
    int   exp_chg_at;
    logic exp_level;
  } vec_t;
  vec_t tbl[17];

  task automatic check_int(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (time %0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 1'b0; m_s2 = 1'b0; m_level = 1'b0; m_run = 0; m_cnt = '0;
    sb_q.delete();
  endtask

  task automatic model_edge(input logic b);
    sb_rec_t rec;
    logic    smp;
    smp  = m_s2;
    m_s2 = m_s1;
    m_s1 = b;
    rec.e_t = 1'b0;
    if (smp != m_level) begin
      m_run++;
      if (m_run == D) begin
        m_level = smp;
        m_run   = 0;
        if (smp) begin
          rec.e_t = 1'b1;
          m_cnt   = m_cnt + 1'b1;
        end
      end
    end else begin
      m_run = 0;
    end
    rec.e_lvl = m_level;
    rec.e_cnt = m_cnt;
    sb_q.push_back(rec);
  endtask

  // Drive one input value across one clock edge, then compare against the scoreboard
  task automatic step(input logic b);
    sb_rec_t rec;
    btn_in = b;
    @(posedge clk);
    model_edge(b);
    #1;
    if (sb_q.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL scoreboard_empty: got 0 entries, expected 1");
    end else begin
      rec = sb_q.pop_front();
      check_int("sb_t", int'(t), int'(rec.e_t));
      check_int("sb_level", int'(btn_level), int'(rec.e_lvl));
      check_int("sb_press_cnt", int'(press_cnt), int'(rec.e_cnt));
    end
  endtask

  // Assert reset between edges, hold it for some edges, then release it just after an edge
  task automatic do_reset(input int cycles, input logic b);
    btn_in = b;
    reset  = 1'b0;
    #1;
    check_int("rst_async_t", int'(t), 0);
    check_int("rst_async_level", int'(btn_level), 0);
    check_int("rst_async_cnt", int'(press_cnt), 0);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      check_int("rst_hold_t", int'(t), 0);
      check_int("rst_hold_level", int'(btn_level), 0);
      check_int("rst_hold_cnt", int'(press_cnt), 0);
    end
    reset = 1'b1;
    model_reset();
  endtask

  // Apply a run of identical inputs and report the pulses and level change seen
  task automatic run_seg(input logic b, input int cycles, output int pulses,
                         output int pulse_at, output int chg_at);
    logic lvl0;
    lvl0 = btn_level;
    pulses = 0; pulse_at = -1; chg_at = -1;
    for (int s = 0; s < cycles; s++) begin
      step(b);
      if (t === 1'b1) begin
        pulses++;
        if (pulse_at < 0) pulse_at = s;
      end
      if ((btn_level !== lvl0) && (chg_at < 0)) chg_at = s;
    end
  endtask

  initial begin
    #1_000_000;
    n_cmp++; n_err++;
    $display("FAIL watchdog: got timeout, expected end of test");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    int pulses, pulse_at, chg_at, total;

    //              btn   cyc  pulses pulse_at chg_at level
    tbl[0]  = '{1'b0,  6, 0, -1, -1, 1'b0};  // idle after reset
    tbl[1]  = '{1'b1, 20, 1,  5,  5, 1'b1};  // clean press
    tbl[2]  = '{1'b0, 10, 0, -1,  5, 1'b0};  // release, same latency
    tbl[3]  = '{1'b1,  1, 0, -1, -1, 1'b0};  // bounce
    tbl[4]  = '{1'b0,  1, 0, -1, -1, 1'b0};
    tbl[5]  = '{1'b1,  1, 0, -1, -1, 1'b0};
    tbl[6]  = '{1'b0,  1, 0, -1, -1, 1'b0};
    tbl[7]  = '{1'b1, 20, 1,  5,  5, 1'b1};  // hold after bounce
    tbl[8]  = '{1'b0, 10, 0, -1,  5, 1'b0};
    tbl[9]  = '{1'b1,  3, 0, -1, -1, 1'b0};  // 3-cycle glitch
    tbl[10] = '{1'b0, 10, 0, -1, -1, 1'b0};
    tbl[11] = '{1'b1, 20, 1,  5,  5, 1'b1};
    tbl[12] = '{1'b0,  3, 0, -1, -1, 1'b1};  // short gap while pressed
    tbl[13] = '{1'b1, 10, 0, -1, -1, 1'b1};  // no auto-repeat
    tbl[14] = '{1'b0, 10, 0, -1,  5, 1'b0};
    tbl[15] = '{1'b1,  4, 0, -1, -1, 1'b0};  // exactly D cycles high
    tbl[16] = '{1'b0, 10, 1,  1,  1, 1'b0};  // accepted late, then released

    model_reset();
    #5;
    do_reset(2, 1'b0);

    for (int i = 0; i < 17; i++) begin
      run_seg(tbl[i].btn, tbl[i].cycles, pulses, pulse_at, chg_at);
      check_int($sformatf("vec%0d_pulses", i), pulses, tbl[i].exp_pulses);
      check_int($sformatf("vec%0d_pulse_at", i), pulse_at, tbl[i].exp_pulse_at);
      check_int($sformatf("vec%0d_chg_at", i), chg_at, tbl[i].exp_chg_at);
      check_int($sformatf("vec%0d_level", i), int'(btn_level), int'(tbl[i].exp_level));
    end
    check_int("table_press_cnt", int'(press_cnt), 4);

    // Counter wrap: 256 clean presses from zero
    do_reset(1, 1'b0);
    total = 0;
    for (int p = 0; p < 256; p++) begin
      run_seg(1'b1, 8, pulses, pulse_at, chg_at);
      total += pulses;
      run_seg(1'b0, 8, pulses, pulse_at, chg_at);
      total += pulses;
      if (p == 254) check_int("wrap_cnt_255", int'(press_cnt), 255);
    end
    check_int("wrap_pulses", total, 256);
    check_int("wrap_cnt_0", int'(press_cnt), 0);

    // Reset at edge 3 of a confirming press, released with the button still high
    run_seg(1'b0, 10, pulses, pulse_at, chg_at);
    run_seg(1'b1, 4, pulses, pulse_at, chg_at);
    check_int("abort_pre_pulses", pulses, 0);
    do_reset(2, 1'b1);
    run_seg(1'b1, 20, pulses, pulse_at, chg_at);
    check_int("abort_pulses", pulses, 1);
    check_int("abort_pulse_at", pulse_at, 5);
    check_int("abort_press_cnt", int'(press_cnt), 1);

    // Reset while t is high drops it at once; a later full hold is a new press
    run_seg(1'b0, 10, pulses, pulse_at, chg_at);
    run_seg(1'b1, 6, pulses, pulse_at, chg_at);
    check_int("tpulse_seen", int'(t), 1);
    do_reset(1, 1'b1);
    run_seg(1'b1, 20, pulses, pulse_at, chg_at);
    check_int("tpulse_after_pulses", pulses, 1);
    check_int("tpulse_after_cnt", int'(press_cnt), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
